// File: rtl/bstep_stream_approx.sv
`default_nettype none
// ============================================================================
//  Module      : bstep_stream_approx
//  Description : Pipelined multi-channel approximate binary-step activation.
//                Each beat carries CH signed WIDTH-bit channels. Every channel
//                and the threshold are arithmetically shifted right by
//                APPROX_BITS, then compared signed: Out1[k] = (xt >= tt).
//                Two register stages (truncate+capture threshold, compare)
//                with valid/ready flow control, 1 beat/cycle throughput and a
//                saturating count of emitted 1-bits.
//
//                Optional build macro BSTEP_HYST_EN: per-channel hysteresis.
//                A channel turns on when xt >= tt, turns off only when
//                xt < tt-HYST, and otherwise holds its previous output.
//
//  Ports       : clk, rst        clock / asynchronous active-high reset
//                In, in_valid, in_ready        input beat stream
//                Out1, out_valid, out_ready    output beat stream
//                cfg_thr, cfg_thr_we           threshold write port
//                cnt_clr, fire_cnt             fire counter clear / value
//
//  Revision    : 1.0  initial release
// ============================================================================
module bstep_stream_approx #(
    parameter int WIDTH       = 6,
    parameter int CH          = 4,
    parameter int APPROX_BITS = 1,
    parameter int CNT_W       = 16,
    parameter int HYST        = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CH*WIDTH-1:0]  In,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [CH-1:0]        Out1,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic [WIDTH-1:0]     cfg_thr,
    input  logic                 cfg_thr_we,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     fire_cnt
);

    // Width of a truncated operand. Taking the top TW bits of a signed value
    // is exactly the arithmetic right shift by APPROX_BITS, and both operands
    // share the same range, so the compare cannot overflow.
    localparam int c_tw = WIDTH - APPROX_BITS;
    localparam int c_pw = $clog2(CH + 1);

    // ------------------------------------------------------------------------
    // Threshold register
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] r_thr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_thr <= '0;
        end else if (cfg_thr_we) begin
            r_thr <= cfg_thr;
        end
    end

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    logic r_s1_v;
    logic r_out_v;
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;
    logic w_xfer;

    assign w_s2_adv  = !r_out_v || out_ready;
    assign w_s1_adv  = !r_s1_v || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign w_accept  = in_valid && w_s1_adv;
    assign w_xfer    = r_out_v && out_ready;
    assign out_valid = r_out_v;

    // ------------------------------------------------------------------------
    // Stage 1: truncated channels plus the threshold in force at accept time.
    // The threshold register still holds the old value on a write edge, so a
    // beat accepted on that edge naturally captures the previous threshold.
    // ------------------------------------------------------------------------
    logic [CH*c_tw-1:0]      w_in_t;
    logic [CH*c_tw-1:0]      r_s1_x;
    logic signed [c_tw-1:0]  r_s1_tt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_v  <= 1'b0;
            r_s1_x  <= '0;
            r_s1_tt <= '0;
        end else if (w_s1_adv) begin
            r_s1_v <= in_valid;
            if (in_valid) begin
                r_s1_x  <= w_in_t;
                r_s1_tt <= r_thr[WIDTH-1:APPROX_BITS];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel truncation and compare
    // ------------------------------------------------------------------------
    logic [CH-1:0] w_ge;
    logic [CH-1:0] w_next;
    logic [CH-1:0] r_out1;

`ifdef BSTEP_HYST_EN
    // Off-threshold computed one bit wider so tt-HYST cannot wrap.
    localparam logic signed [c_tw:0] c_hyst = (c_tw + 1)'(HYST);
    logic signed [c_tw:0] w_tlow;
    assign w_tlow = $signed({r_s1_tt[c_tw-1], r_s1_tt}) - c_hyst;
`endif

    genvar k;
    generate
        for (k = 0; k < CH; k++) begin : g_ch
            logic signed [c_tw-1:0] w_xt;

            assign w_in_t[k*c_tw +: c_tw] = In[k*WIDTH + APPROX_BITS +: c_tw];
            assign w_xt    = r_s1_x[k*c_tw +: c_tw];
            assign w_ge[k] = (w_xt >= r_s1_tt);

`ifdef BSTEP_HYST_EN
            logic signed [c_tw:0] w_xw;
            logic                 w_lo;
            assign w_xw      = {w_xt[c_tw-1], w_xt};
            assign w_lo      = (w_xw < w_tlow);
            // Output register doubles as the hysteresis state bit.
            assign w_next[k] = w_ge[k] || (!w_lo && r_out1[k]);
`else
            assign w_next[k] = w_ge[k];
`endif
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Stage 2: compare result. Holds while stalled downstream.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_v <= 1'b0;
            r_out1  <= '0;
        end else if (w_s2_adv) begin
            r_out_v <= r_s1_v;
            if (r_s1_v) begin
                r_out1 <= w_next;
            end
        end
    end

    assign Out1 = r_out1;

    // ------------------------------------------------------------------------
    // Saturating fire counter
    // ------------------------------------------------------------------------
    logic [c_pw-1:0]  w_pop;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] r_cnt;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < CH; i++) begin
            w_pop = w_pop + c_pw'(r_out1[i]);
        end
    end

    assign w_sum = {1'b0, r_cnt} + (CNT_W + 1)'(w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
        end
    end

    assign fire_cnt = r_cnt;

    // Discarded LSBs of the data and threshold are intentionally unused.
    logic w_unused_bits;
    assign w_unused_bits = ^{In, r_thr};

endmodule
`default_nettype wire

// File: tb/tb_bstep_stream_approx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bstep_stream_approx
//  Description : Directed self-checking bench. Two instances share stimulus:
//                u_dut  (exact compare, APPROX_BITS=0, CNT_W=16)
//                u_dut2 (APPROX_BITS=2, CNT_W=4 for saturation).
//                Expected values are hand-computed constants; the hysteresis
//                expectations follow BSTEP_HYST_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bstep_stream_approx;

    localparam int c_w  = 6;
    localparam int c_ch = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [c_ch*c_w-1:0]   r_in;
    logic                  r_in_valid;
    logic                  r_out_ready;
    logic [c_w-1:0]        r_cfg_thr;
    logic                  r_cfg_thr_we;
    logic                  r_cnt_clr;

    logic                  w_in_ready_a,  w_in_ready_b;
    logic [c_ch-1:0]       w_out1_a,      w_out1_b;
    logic                  w_out_valid_a, w_out_valid_b;
    logic [15:0]           w_cnt_a;
    logic [3:0]            w_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bstep_stream_approx #(
        .WIDTH(c_w), .CH(c_ch), .APPROX_BITS(0), .CNT_W(16), .HYST(2)
    ) u_dut (
        .clk(clk), .rst(rst), .In(r_in), .in_valid(r_in_valid),
        .in_ready(w_in_ready_a), .Out1(w_out1_a), .out_valid(w_out_valid_a),
        .out_ready(r_out_ready), .cfg_thr(r_cfg_thr), .cfg_thr_we(r_cfg_thr_we),
        .cnt_clr(r_cnt_clr), .fire_cnt(w_cnt_a)
    );

    bstep_stream_approx #(
        .WIDTH(c_w), .CH(c_ch), .APPROX_BITS(2), .CNT_W(4), .HYST(2)
    ) u_dut2 (
        .clk(clk), .rst(rst), .In(r_in), .in_valid(r_in_valid),
        .in_ready(w_in_ready_b), .Out1(w_out1_b), .out_valid(w_out_valid_b),
        .out_ready(r_out_ready), .cfg_thr(r_cfg_thr), .cfg_thr_we(r_cfg_thr_we),
        .cnt_clr(r_cnt_clr), .fire_cnt(w_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; return 1 time unit later (sample/drive point).
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [c_ch*c_w-1:0] pack(input int a0, input int a1,
                                                 input int a2, input int a3);
        logic [c_w-1:0] b0, b1, b2, b3;
        b0 = c_w'(a0); b1 = c_w'(a1); b2 = c_w'(a2); b3 = c_w'(a3);
        return {b3, b2, b1, b0};
    endfunction

    int   hseq [5] = '{1, -1, -2, -3, 0};
`ifdef BSTEP_HYST_EN
    logic hexp [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
    logic hexp [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`endif

    initial begin
        rst          = 1'b1;
        r_in         = '0;
        r_in_valid   = 1'b0;
        r_out_ready  = 1'b1;
        r_cfg_thr    = '0;
        r_cfg_thr_we = 1'b0;
        r_cnt_clr    = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // ---------------- reset state ----------------
        check("rst_out_valid", 32'(w_out_valid_a), 32'd0);
        check("rst_out1",      32'(w_out1_a),      32'd0);
        check("rst_cnt",       32'(w_cnt_a),       32'd0);
        check("rst_in_ready",  32'(w_in_ready_a),  32'd1);

        // ---------------- exact compare, thr=0 ----------------
        r_in       = pack(-1, 0, 5, -32);
        r_in_valid = 1'b1;
        step();                                   // accept
        r_in_valid = 1'b0;
        check("lat1_out_valid", 32'(w_out_valid_a), 32'd0);
        step();                                   // 2 cycles after accept
        check("lat2_out_valid", 32'(w_out_valid_a), 32'd1);
        check("exact_out1",     32'(w_out1_a),      32'h6);
        check("exact_out1_a2",  32'(w_out1_b),      32'h6);
        step();                                   // transfer
        check("exact_drain",    32'(w_out_valid_a), 32'd0);
        check("exact_cnt",      32'(w_cnt_a),       32'd2);
        check("exact_cnt_a2",   32'(w_cnt_b),       32'd2);

        // ---------------- approx compare, thr=4, write on accept ----------------
        r_cfg_thr    = 6'd4;
        r_cfg_thr_we = 1'b1;
        step();
        r_in         = pack(3, 4, 7, -1);
        r_in_valid   = 1'b1;
        r_cfg_thr    = 6'b100000;                 // -32, written on accept edge
        step();                                   // accept beat A with old thr
        r_cfg_thr_we = 1'b0;
        step();                                   // accept beat B with thr=-32
        r_in_valid   = 1'b0;
        check("approx_oldthr_a2",   32'(w_out1_b), 32'h6);
        check("approx_oldthr_exact",32'(w_out1_a), 32'h6);
        step();
        check("approx_newthr_a2",   32'(w_out1_b), 32'hF);
        check("approx_newthr_exact",32'(w_out1_a), 32'hF);
        step();
        check("approx_cnt",    32'(w_cnt_a), 32'd8);
        check("approx_cnt_a2", 32'(w_cnt_b), 32'd8);
        r_cfg_thr    = '0;
        r_cfg_thr_we = 1'b1;
        step();
        r_cfg_thr_we = 1'b0;

        // ---------------- backpressure ----------------
        r_out_ready = 1'b0;
        r_in        = pack(1, -32, -32, -32);
        r_in_valid  = 1'b1;
        step();
        r_in = pack(-32, 1, -32, -32);
        check("bp_ready_2nd", 32'(w_in_ready_a), 32'd1);
        step();
        r_in = pack(-32, -32, 1, -32);
        check("bp_ready_3rd",  32'(w_in_ready_a), 32'd0);
        check("bp_valid",      32'(w_out_valid_a), 32'd1);
        check("bp_out1",       32'(w_out1_a),      32'h1);
        step();
        step();
        check("bp_stable_out1",  32'(w_out1_a),      32'h1);
        check("bp_stable_valid", 32'(w_out_valid_a), 32'd1);
        check("bp_stable_ready", 32'(w_in_ready_b),  32'd0);
        r_out_ready = 1'b1;
        #1;
        check("bp_ready_comb", 32'(w_in_ready_a), 32'd1);
        step();                                   // C1 out, C3 accepted
        r_in_valid = 1'b0;
        check("bp_order2",    32'(w_out1_a), 32'h2);
        check("bp_order2_a2", 32'(w_out1_b), 32'h2);
        step();
        check("bp_order3",    32'(w_out1_a), 32'h4);
        check("bp_order3_v",  32'(w_out_valid_a), 32'd1);
        step();
        check("bp_drain",  32'(w_out_valid_a), 32'd0);
        check("bp_cnt",    32'(w_cnt_a), 32'd11);
        check("bp_cnt_a2", 32'(w_cnt_b), 32'd11);

        // ---------------- counter saturation and clear ----------------
        r_cnt_clr = 1'b1;
        step();
        r_cnt_clr = 1'b0;
        check("clr_idle", 32'(w_cnt_b), 32'd0);
        r_in       = pack(31, 31, 31, 31);
        r_in_valid = 1'b1;
        repeat (5) step();
        r_in_valid = 1'b0;
        repeat (3) step();
        check("sat_cnt_a2",  32'(w_cnt_b), 32'd15);
        check("sat_cnt_w16", 32'(w_cnt_a), 32'd20);
        r_in_valid = 1'b1;
        step();
        r_in_valid = 1'b0;
        step();
        check("clr_pre_valid", 32'(w_out_valid_b), 32'd1);
        r_cnt_clr = 1'b1;
        step();                                   // transfer + clear same edge
        r_cnt_clr = 1'b0;
        check("clr_xfer_a2", 32'(w_cnt_b), 32'd0);
        check("clr_xfer",    32'(w_cnt_a), 32'd0);

        // ---------------- hysteresis sequence on ch0 ----------------
        for (int i = 0; i < 5; i++) begin
            r_in       = pack(hseq[i], 0, 0, 0);
            r_in_valid = 1'b1;
            step();
            if (i >= 1) begin
                check($sformatf("hyst_%0d", i - 1), 32'(w_out1_a[0]), 32'(hexp[i-1]));
            end
        end
        r_in_valid = 1'b0;
        step();
        check("hyst_4", 32'(w_out1_a[0]), 32'(hexp[4]));
        step();

        // ---------------- reset mid-stream ----------------
        r_out_ready = 1'b0;
        r_in        = pack(5, 5, 5, 5);
        r_in_valid  = 1'b1;
        step();
        step();
        r_in_valid = 1'b0;
        check("mid_inflight", 32'(w_out_valid_a), 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(w_out_valid_a), 32'd0);
        check("mid_rst_out1",  32'(w_out1_a),      32'd0);
        check("mid_rst_cnt",   32'(w_cnt_a),       32'd0);
        repeat (3) step();
        rst = 1'b0;
        step();
        check("mid_ready", 32'(w_in_ready_a), 32'd1);
        r_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("mid_stale_%0d", i), 32'(w_out_valid_a | w_out_valid_b), 32'd0);
        end
        check("mid_cnt_after", 32'(w_cnt_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
